// File: rtl/dft_fpga_core.sv
// PL-side register block of the Zynq DFT test design: ID, scratch, and a
// programmable countdown engine that raises a level interrupt when it expires.
module dft_fpga_core #(
    parameter int ADDR_WIDTH = 24
) (
    input  logic                  AXI_S_ACLK,
    input  logic                  AXI_S_ARESETn,
    input  logic                  AXI_S_AWVALID,
    output logic                  AXI_S_AWREADY,
    input  logic [ADDR_WIDTH-1:0] AXI_S_AWADDR,
    input  logic [2:0]            AXI_S_AWPROT,
    input  logic                  AXI_S_WVALID,
    output logic                  AXI_S_WREADY,
    input  logic [31:0]           AXI_S_WDATA,
    input  logic [3:0]            AXI_S_WSTRB,
    output logic                  AXI_S_BVALID,
    input  logic                  AXI_S_BREADY,
    output logic [1:0]            AXI_S_BRESP,
    input  logic                  AXI_S_ARVALID,
    output logic                  AXI_S_ARREADY,
    input  logic [ADDR_WIDTH-1:0] AXI_S_ARADDR,
    input  logic [2:0]            AXI_S_ARPROT,
    output logic                  AXI_S_RVALID,
    input  logic                  AXI_S_RREADY,
    output logic [31:0]           AXI_S_RDATA,
    output logic [1:0]            AXI_S_RRESP,
    output logic                  INTERRUPT
);

    localparam logic [31:0] ID_VALUE    = 32'h4446_5400;
    localparam logic [5:0]  IDX_ID      = 6'd0;
    localparam logic [5:0]  IDX_SCRATCH = 6'd1;
    localparam logic [5:0]  IDX_CTRL    = 6'd2;
    localparam logic [5:0]  IDX_STATUS  = 6'd3;
    localparam logic [5:0]  IDX_COUNT   = 6'd4;
    localparam logic [5:0]  IDX_REMAIN  = 6'd5;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    logic [31:0] scratch;
    logic [31:0] count;
    logic [31:0] remain;
    logic        irq_en;
    logic        busy;
    logic        done;

    logic        wr_fire;
    logic        rd_fire;
    logic [5:0]  wr_idx;
    logic [5:0]  rd_idx;
    logic        go;
    logic        done_clr;
    logic        done_set;
    logic [31:0] rd_word;
    logic        rd_err;
    logic        unused_inputs;

    // Handshakes: a transfer happens on the rising edge where VALID and READY
    // are both high. READY is a registered one-cycle pulse, and a response
    // VALID holds with stable payload until its READY is seen.
    assign wr_fire = AXI_S_AWVALID & AXI_S_AWREADY & AXI_S_WVALID & AXI_S_WREADY;
    assign rd_fire = AXI_S_ARVALID & AXI_S_ARREADY;
    assign wr_idx  = AXI_S_AWADDR[7:2];
    assign rd_idx  = AXI_S_ARADDR[7:2];

    assign go       = wr_fire && (wr_idx == IDX_CTRL) && AXI_S_WSTRB[0] && AXI_S_WDATA[0];
    assign done_clr = wr_fire && (wr_idx == IDX_STATUS) && AXI_S_WSTRB[0] && AXI_S_WDATA[1];
    assign done_set = go ? (count == 32'd0) : (busy && (remain == 32'd1));

    assign INTERRUPT = done & irq_en;

    assign unused_inputs = ^{AXI_S_AWPROT, AXI_S_ARPROT,
                             AXI_S_AWADDR[ADDR_WIDTH-1:8], AXI_S_AWADDR[1:0],
                             AXI_S_ARADDR[ADDR_WIDTH-1:8], AXI_S_ARADDR[1:0]};

    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

    always_comb begin
        rd_word = 32'd0;
        rd_err  = 1'b0;
        case (rd_idx)
            IDX_ID:      rd_word = ID_VALUE;
            IDX_SCRATCH: rd_word = scratch;
            IDX_CTRL:    rd_word = {30'd0, irq_en, 1'b0};
            IDX_STATUS:  rd_word = {30'd0, done, busy};
            IDX_COUNT:   rd_word = count;
            IDX_REMAIN:  rd_word = remain;
            default:     rd_err  = 1'b1;
        endcase
    end

    always_ff @(posedge AXI_S_ACLK) begin
        if (!AXI_S_ARESETn) begin
            AXI_S_AWREADY <= 1'b0;
            AXI_S_WREADY  <= 1'b0;
            AXI_S_BVALID  <= 1'b0;
            AXI_S_BRESP   <= RESP_OKAY;
            scratch       <= 32'd0;
            count         <= 32'd0;
            irq_en        <= 1'b0;
        end else begin
            AXI_S_AWREADY <= 1'b0;
            AXI_S_WREADY  <= 1'b0;
            if (AXI_S_AWVALID && AXI_S_WVALID && !AXI_S_BVALID && !AXI_S_AWREADY) begin
                AXI_S_AWREADY <= 1'b1;
                AXI_S_WREADY  <= 1'b1;
            end
            if (wr_fire) begin
                AXI_S_BVALID <= 1'b1;
                AXI_S_BRESP  <= (wr_idx > IDX_REMAIN) ? RESP_SLVERR : RESP_OKAY;
                case (wr_idx)
                    IDX_SCRATCH: scratch <= apply_strb(scratch, AXI_S_WDATA, AXI_S_WSTRB);
                    IDX_CTRL:    if (AXI_S_WSTRB[0]) irq_en <= AXI_S_WDATA[1];
                    IDX_COUNT:   count <= apply_strb(count, AXI_S_WDATA, AXI_S_WSTRB);
                    default:     ;
                endcase
            end else if (AXI_S_BREADY) begin
                AXI_S_BVALID <= 1'b0;
            end
        end
    end

    always_ff @(posedge AXI_S_ACLK) begin
        if (!AXI_S_ARESETn) begin
            AXI_S_ARREADY <= 1'b0;
            AXI_S_RVALID  <= 1'b0;
            AXI_S_RDATA   <= 32'd0;
            AXI_S_RRESP   <= RESP_OKAY;
        end else begin
            AXI_S_ARREADY <= AXI_S_ARVALID && !AXI_S_RVALID && !AXI_S_ARREADY;
            if (rd_fire) begin
                AXI_S_RVALID <= 1'b1;
                AXI_S_RDATA  <= rd_word;
                AXI_S_RRESP  <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end else if (AXI_S_RREADY) begin
                AXI_S_RVALID <= 1'b0;
            end
        end
    end

    // A zero load finishes at the GO edge itself; otherwise the last decrement
    // (REMAIN 1 -> 0) is the edge that drops BUSY and sets DONE.
    always_ff @(posedge AXI_S_ACLK) begin
        if (!AXI_S_ARESETn) begin
            remain <= 32'd0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            if (go) begin
                remain <= count;
                busy   <= (count != 32'd0);
            end else if (busy) begin
                remain <= remain - 32'd1;
                if (remain == 32'd1) busy <= 1'b0;
            end
            if (done_set)      done <= 1'b1;
            else if (done_clr) done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dft_fpga_core.sv
// Directed-plus-random bench for dft_fpga_core: AXI-Lite driver tasks, an
// edge-indexed reference model of the register map and countdown, and a summary.
module tb_dft_fpga_core;
    localparam int AW = 24;
    localparam logic [31:0] ID_VALUE = 32'h4446_5400;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready, interrupt;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic [31:0]   wdata, rdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;

    dft_fpga_core #(.ADDR_WIDTH(AW)) dut (
        .AXI_S_ACLK(clk), .AXI_S_ARESETn(rstn),
        .AXI_S_AWVALID(awvalid), .AXI_S_AWREADY(awready), .AXI_S_AWADDR(awaddr),
        .AXI_S_AWPROT(awprot), .AXI_S_WVALID(wvalid), .AXI_S_WREADY(wready),
        .AXI_S_WDATA(wdata), .AXI_S_WSTRB(wstrb), .AXI_S_BVALID(bvalid),
        .AXI_S_BREADY(bready), .AXI_S_BRESP(bresp), .AXI_S_ARVALID(arvalid),
        .AXI_S_ARREADY(arready), .AXI_S_ARADDR(araddr), .AXI_S_ARPROT(arprot),
        .AXI_S_RVALID(rvalid), .AXI_S_RREADY(rready), .AXI_S_RDATA(rdata),
        .AXI_S_RRESP(rresp), .INTERRUPT(interrupt)
    );

    // ---------------- clock / reset / cycle index ----------------
    always #5 clk = ~clk;
    int cyc = 0;  // number of rising edges so far; stable at negedges
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int irq_rise = -1;
    logic irq_q = 1'b0;
    always @(negedge clk) begin
        if (interrupt && !irq_q) irq_rise = cyc;
        irq_q = interrupt;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model (state after edge e) ----------------
    logic [31:0] m_scratch, m_count;
    logic        m_irq_en;
    int          m_go, m_n, m_clr;

    task automatic m_reset();
        m_scratch = 0; m_count = 0; m_irq_en = 0;
        m_go = -1; m_n = 0; m_clr = -1000;
    endtask

    function automatic logic [31:0] m_merge(input logic [31:0] o, input logic [31:0] d,
                                            input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic m_busy(input int e);
        return (m_go >= 0) && (e >= m_go) && (e < m_go + m_n);
    endfunction

    function automatic logic [31:0] m_remain(input int e);
        if (m_go < 0 || e < m_go) return 32'd0;
        return (m_n > e - m_go) ? 32'(m_n - (e - m_go)) : 32'd0;
    endfunction

    function automatic logic m_done(input int e);
        int fin;
        if (m_go < 0) return 1'b0;
        fin = m_go + m_n;
        return (e >= fin) && !(m_clr > fin && m_clr <= e);
    endfunction

    function automatic logic [31:0] m_read(input logic [AW-1:0] a, input int e);
        case (a[7:2])
            6'd0: return ID_VALUE;
            6'd1: return m_scratch;
            6'd2: return {30'd0, m_irq_en, 1'b0};
            6'd3: return {30'd0, m_done(e), m_busy(e)};
            6'd4: return m_count;
            6'd5: return m_remain(e);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [1:0] m_resp(input logic [AW-1:0] a);
        return (a[7:2] > 6'd5) ? 2'b10 : 2'b00;
    endfunction

    task automatic m_apply(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int e);
        case (a[7:2])
            6'd1: m_scratch = m_merge(m_scratch, d, s);
            6'd2: if (s[0]) begin
                m_irq_en = d[1];
                if (d[0]) begin m_go = e; m_n = int'(m_count); end
            end
            6'd3: if (s[0] && d[1]) m_clr = e;
            6'd4: m_count = m_merge(m_count, d, s);
            default: ;
        endcase
    endtask

    function automatic logic [AW-1:0] alias_addr(input logic [5:0] idx);
        logic [AW-1:0] a;
        a = AW'($urandom());
        a[7:2] = idx;
        return a;
    endfunction

    // ---------------- scoreboard check ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks (called at a negedge context) ----------------
    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int stall, output logic [1:0] resp, output int acc);
        int t;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awprot = 3'($urandom()); awvalid = 1; wvalid = 1;
        t = 0;
        while (!(awready && wready) && t < 20) begin @(negedge clk); t++; end
        if (t >= 20) begin
            chk("aw_timeout", 1, 0);
            awvalid = 0; wvalid = 0; resp = 2'b11; acc = -1;
        end else begin
            acc = cyc + 1;
            @(negedge clk);
            awvalid = 0; wvalid = 0;
            m_apply(a, d, s, acc);
            chk("bvalid_latency", bvalid, 1);
            resp = bresp;
            for (int i = 0; i < stall; i++) begin
                awaddr = '0; awvalid = 1; wvalid = 1;
                @(negedge clk);
                chk("bvalid_hold", bvalid, 1);
                chk("bresp_hold", bresp, resp);
                chk("aw_blocked", awready, 0);
            end
            awvalid = 0; wvalid = 0; bready = 1;
            @(negedge clk);
            bready = 0;
            chk("bvalid_clear", bvalid, 0);
        end
    endtask

    task automatic axi_read(input logic [AW-1:0] a, input int stall,
                            output logic [31:0] d, output logic [1:0] resp, output int acc);
        int t;
        @(negedge clk);
        araddr = a; arprot = 3'($urandom()); arvalid = 1;
        t = 0;
        while (!arready && t < 20) begin @(negedge clk); t++; end
        if (t >= 20) begin
            chk("ar_timeout", 1, 0);
            arvalid = 0; d = 32'hdead_beef; resp = 2'b11; acc = -1;
        end else begin
            acc = cyc + 1;
            @(negedge clk);
            arvalid = 0;
            chk("rvalid_latency", rvalid, 1);
            d = rdata; resp = rresp;
            for (int i = 0; i < stall; i++) begin
                arvalid = 1;
                @(negedge clk);
                chk("rvalid_hold", rvalid, 1);
                chk("rdata_hold", rdata, d);
                chk("ar_blocked", arready, 0);
            end
            arvalid = 0; rready = 1;
            @(negedge clk);
            rready = 0;
            chk("rvalid_clear", rvalid, 0);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int stall, output int acc);
        logic [1:0] r;
        axi_write(a, d, s, stall, r, acc);
        chk("bresp", r, m_resp(a));
    endtask

    task automatic rd_chk(input string tag, input logic [AW-1:0] a, input int stall);
        logic [31:0] d;
        logic [1:0]  r;
        int acc;
        axi_read(a, stall, d, r, acc);
        chk(tag, d, m_read(a, acc - 1));
        chk({tag, "_rresp"}, r, m_resp(a));
    endtask

    task automatic wait_until(input int e);
        int t;
        t = 0;
        while (cyc < e && t < 300) begin @(negedge clk); t++; end
        if (cyc < e) chk("wait_timeout", 1, 0);
    endtask

    // ---------------- directed + random sequence ----------------
    int acc, acc2, tgo, n;
    logic [31:0] d, exp_old;
    logic [1:0]  r;

    initial begin
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0; awprot = '0; arprot = '0;
        m_reset();
        repeat (3) @(negedge clk);
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_arready", arready, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_irq", interrupt, 0);
        rstn = 1;

        rd_chk("id", 24'h0, 0);
        rd_chk("status_rst", 24'h0C, 0);
        rd_chk("remain_rst", 24'h14, 0);

        wr(24'h04, 32'hA5A5_1234, 4'b0011, 0, acc);
        rd_chk("scratch_strb", 24'h04, 0);
        chk("scratch_const", m_scratch, 32'h0000_1234);
        rd_chk("scratch_alias", 24'h104, 0);

        for (int i = 0; i < 6; i++) begin
            logic [5:0] idx;
            idx = ($urandom_range(0, 1) == 0) ? 6'd1 : 6'd4;
            wr(alias_addr(idx), $urandom(), 4'($urandom_range(0, 15)), 0, acc);
            rd_chk("rand_rw", alias_addr(idx), 0);
        end

        // countdown of 5 with interrupt enabled
        wr(24'h10, 32'd5, 4'hF, 0, acc);
        irq_rise = -1;
        wr(24'h08, 32'h3, 4'h1, 0, tgo);
        rd_chk("busy_5", 24'h0C, 0);
        wait_until(tgo + 6);
        chk("irq_time_5", irq_rise, tgo + 5);
        chk("irq_level_5", interrupt, m_done(cyc) & m_irq_en);
        rd_chk("done_5", 24'h0C, 0);
        wr(24'h0C, 32'h2, 4'h1, 0, acc);
        @(negedge clk);
        chk("irq_cleared", interrupt, 0);
        rd_chk("status_cleared", 24'h0C, 0);

        for (int i = 0; i < 3; i++) begin
            n = $urandom_range(10, 25);
            wr(alias_addr(6'd4), 32'(n), 4'hF, 0, acc);
            irq_rise = -1;
            wr(alias_addr(6'd2), 32'h3, 4'h1, 0, tgo);
            for (int k = 0; k < 3; k++) rd_chk("remain_poll", alias_addr(6'd5), 0);
            rd_chk("busy_poll", alias_addr(6'd3), 0);
            wait_until(tgo + n + 1);
            chk("irq_time_rand", irq_rise, tgo + n);
            wr(24'h0C, 32'h2, 4'b1110, 0, acc);
            rd_chk("w1c_no_strb", 24'h0C, 0);
            wr(24'h0C, 32'hFFFF_FFFF, 4'hF, 0, acc);
            rd_chk("w1c_clear", 24'h0C, 0);
        end

        // countdown with IRQ_EN=0, then enable afterwards
        wr(24'h10, 32'd4, 4'hF, 0, acc);
        irq_rise = -1;
        wr(24'h08, 32'h1, 4'h1, 0, tgo);
        wait_until(tgo + 5);
        rd_chk("done_noirq", 24'h0C, 0);
        chk("irq_masked", interrupt, 0);
        chk("irq_never", irq_rise, -1);
        wr(24'h08, 32'h2, 4'h1, 0, acc);
        @(negedge clk);
        chk("irq_late_enable", interrupt, m_done(cyc) & m_irq_en);
        rd_chk("ctrl_read", 24'h08, 0);
        wr(24'h08, 32'h1, 4'b1110, 0, acc);
        rd_chk("ctrl_no_strb", 24'h08, 0);
        rd_chk("no_go_no_strb", 24'h0C, 0);
        wr(24'h0C, 32'h2, 4'h1, 0, acc);

        // unmapped and read-only targets, with back-pressure
        wr(24'h20, $urandom(), 4'hF, 4, acc);
        rd_chk("unmapped_20", 24'h20, 4);
        wr(alias_addr(6'($urandom_range(6, 63))), $urandom(), 4'hF, 0, acc);
        rd_chk("unmapped_rand", alias_addr(6'($urandom_range(6, 63))), 2);
        wr(24'h00, 32'h1234_5678, 4'hF, 0, acc);
        rd_chk("id_ro", 24'h00, 0);
        wr(24'h14, 32'h1234_5678, 4'hF, 0, acc);
        rd_chk("remain_ro", 24'h14, 0);

        // read and write of SCRATCH accepted together: read sees the old value
        exp_old = m_scratch;
        fork
            wr(24'h04, 32'hC0DE_0001 ^ exp_old, 4'hF, 0, acc);
            axi_read(24'h04, 0, d, r, acc2);
        join
        chk("same_edge", acc2, acc);
        chk("rd_pre_write", d, exp_old);
        rd_chk("rd_post_write", 24'h04, 0);

        // COUNT=0 finishes at the GO edge
        wr(24'h10, 32'd0, 4'hF, 0, acc);
        irq_rise = -1;
        wr(24'h08, 32'h3, 4'h1, 0, tgo);
        chk("irq_time_0", irq_rise, tgo);
        rd_chk("done_0", 24'h0C, 0);
        wr(24'h0C, 32'h2, 4'h1, 0, acc);

        // restart while busy reloads from COUNT
        wr(24'h10, 32'd40, 4'hF, 0, acc);
        wr(24'h08, 32'h3, 4'h1, 0, acc);
        wr(24'h10, 32'd6, 4'hF, 0, acc);
        irq_rise = -1;
        wr(24'h08, 32'h3, 4'h1, 0, tgo);
        rd_chk("remain_restart", 24'h14, 0);
        wait_until(tgo + 7);
        chk("irq_time_restart", irq_rise, tgo + 6);
        wr(24'h0C, 32'h2, 4'h1, 0, acc);

        // reset mid-countdown
        wr(24'h10, 32'd100, 4'hF, 0, acc);
        wr(24'h08, 32'h3, 4'h1, 0, tgo);
        wait_until(tgo + 10);
        rd_chk("busy_pre_reset", 24'h0C, 0);
        @(negedge clk);
        rstn = 0;
        @(negedge clk);
        rstn = 1;
        m_reset();
        chk("irq_after_reset", interrupt, 0);
        rd_chk("status_after_reset", 24'h0C, 0);
        rd_chk("remain_after_reset", 24'h14, 0);
        rd_chk("count_after_reset", 24'h10, 0);
        rd_chk("ctrl_after_reset", 24'h08, 0);
        rd_chk("scratch_after_reset", 24'h04, 0);
        wait_until(tgo + 110);
        chk("no_irq_after_reset", interrupt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
